apb_rr_master: RTL and testbench

//  Round-robin APB requester arbiter and master sequencer. Shares one APB slave port (dpmem) among
//  NUM_REQ on-chip requesters. Grants one request at a time, drives SETUP/ACCESS phases, honours

---
 rtl/apb_rr_master.sv | 144 ++++++++++++++
 tb/tb_apb_rr_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - round-robin APB requester arbiter and master sequencer
// Grants one requester at a time onto a shared APB slave, with wait states and timeout abort.
module apb_rr_master #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic                      PREADY,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PSLVERR
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_d;
  logic [IW-1:0] rr_ptr, cur, win, cand, win_next;
  logic [CW-1:0] cnt;
  logic          any_req, accept, done, abort;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  assign win_next = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done = 1'b1;
          if (any_req) begin
            accept  = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (accept && !PRESET) ? (NUM_REQ'(1) << win) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur       <= '0;
      cnt       <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;

      if (done) begin
        rsp_valid <= NUM_REQ'(1) << cur;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (abort) begin
        rsp_valid <= NUM_REQ'(1) << cur;
        rsp_err   <= 1'b1;
      end

      // A completing transfer can hand the bus straight to the next winner.
      if (accept) begin
        cur     <= win;
        rr_ptr  <= win_next;
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PADDR   <= req_addr[win*ADDR_W +: ADDR_W];
        PWRITE  <= req_write[win];
        PWDATA  <= req_write[win] ? req_wdata[win*DATA_W +: DATA_W] : '0;
      end else if (done || abort) begin
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
        PWDATA  <= '0;
      end else if (state == SETUP) begin
        PENABLE <= 1'b1;
      end

      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS && !done && !abort && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master
// Transaction-level reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_apb_rr_master;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic                PCLK, PRESET;
  logic [NUM_REQ-1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [NUM_REQ*32-1:0] req_addr, req_wdata;
  logic [31:0]         rsp_rdata, PADDR, PWDATA, PRDATA;
  logic                rsp_err, busy, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  apb_rr_master #(.NUM_REQ(NUM_REQ), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Slave responder: PREADY rises after wait_states ACCESS cycles, never when stuck.
  int wait_states = 0;
  bit stuck = 1'b0;
  bit in_acc = 1'b0;
  int acc_n = 0;
  initial begin
    PREADY = 1'b0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && PENABLE) begin
        acc_n  = in_acc ? acc_n + 1 : 0;
        in_acc = 1'b1;
      end else begin
        in_acc = 1'b0;
        acc_n  = 0;
      end
      PREADY = PSEL && PENABLE && !stuck && (acc_n >= wait_states);
    end
  end

  // Reference model: a transfer is busy for a number of cycles counted since its accept.
  bit          m_busy = 1'b0, m_write = 1'b0, m_rsp_v = 1'b0, m_rsp_err = 1'b0;
  int          m_age = 0, m_owner = 0, m_ptr = 0, m_rsp_idx = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rsp_data = '0;

  always @(negedge PCLK) begin
    logic [NUM_REQ-1:0] exp_rdy, exp_rv;
    int w;
    if (PRESET) begin
      chk("rst_ctrl", {req_ready, rsp_valid, rsp_err, busy, PSEL, PENABLE, PWRITE}, 0);
      chk("rst_data", {PADDR, PWDATA}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      m_busy = 1'b0; m_ptr = 0; m_rsp_v = 1'b0; m_addr = '0;
    end else begin
      exp_rdy = '0;
      exp_rv  = '0;
      w = -1;
      if (!m_busy || (m_age >= 2 && PREADY))
        for (int k = 0; k < NUM_REQ; k++)
          if (w < 0 && req_valid[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
      if (w >= 0) exp_rdy[w] = 1'b1;
      if (m_rsp_v) exp_rv[m_rsp_idx] = 1'b1;
      chk("m_req_ready", req_ready, exp_rdy);
      chk("m_psel", PSEL, m_busy);
      chk("m_busy", busy, m_busy);
      chk("m_penable", PENABLE, m_busy && m_age >= 2);
      chk("m_paddr", PADDR, m_addr);
      chk("m_pwdata", PWDATA, (m_busy && m_write) ? m_wdata : 32'h0);
      if (m_busy) chk("m_pwrite", PWRITE, m_write);
      chk("m_rsp_valid", rsp_valid, exp_rv);
      chk("m_rsp_rdata", rsp_rdata, m_rsp_v ? m_rsp_data : 32'h0);
      chk("m_rsp_err", rsp_err, m_rsp_v && m_rsp_err);

      m_rsp_v = 1'b0;
      if (m_busy && m_age >= 2) begin
        if (PREADY) begin
          m_rsp_v = 1'b1; m_rsp_idx = m_owner; m_rsp_err = PSLVERR;
          m_rsp_data = m_write ? 32'h0 : PRDATA;
          m_busy = 1'b0;
        end else if (TIMEOUT > 0 && m_age - 1 == TIMEOUT) begin
          m_rsp_v = 1'b1; m_rsp_idx = m_owner; m_rsp_err = 1'b1; m_rsp_data = 32'h0;
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (m_busy) begin
        m_age = 2;
      end
      if (w >= 0) begin
        m_busy  = 1'b1; m_age = 1; m_owner = w;
        m_addr  = req_addr[w*32 +: 32];
        m_wdata = req_wdata[w*32 +: 32];
        m_write = req_write[w];
        m_ptr   = (w + 1) % NUM_REQ;
      end
    end
  end

  // Raise one request, wait for its accept, drop it after the accept edge.
  task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    req_write[i] = wr;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge PCLK);
      if (req_ready[i]) begin got = 1'b1; break; end
    end
    chk("ready_seen", got, 1);
    @(posedge PCLK);
    #1;
    req_valid[i] = 1'b0;
  endtask

  // Counts cycles from SETUP (=1) up to the response cycle; leaves the caller at that negedge.
  task automatic wait_rsp(input int i, output int lat, output int en,
                          output logic [31:0] rd, output logic er);
    bit got = 1'b0;
    lat = 0; en = 0; rd = '0; er = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge PCLK);
      lat++;
      if (PENABLE) en++;
      if (rsp_valid[i]) begin got = 1'b1; rd = rsp_rdata; er = rsp_err; break; end
    end
    chk("rsp_seen", got, 1);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge PCLK);
      if (!busy) begin got = 1'b1; break; end
    end
    chk("idle_reached", got, 1);
    @(posedge PCLK);
    #1;
  endtask

  int          lat, en, n_gr, rv;
  logic [31:0] rd;
  logic        er;
  logic [NUM_REQ-1:0] seen;
  int          exp_seq [5] = '{0, 1, 2, 3, 0};
  bit          psel_gap;

  initial begin
    PRESET = 1'b1;
    PRDATA = '0;
    PSLVERR = 1'b0;
    req_valid = 4'hF;
    req_write = 4'b0101;
    req_addr  = {32'h300, 32'h200, 32'h100, 32'h000};
    req_wdata = {32'h33, 32'h22, 32'h11, 32'h0A};
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;

    // All four held from reset: 0,1,2,3,0 with no PSEL gap.
    n_gr = 0;
    psel_gap = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge PCLK);
      if (n_gr > 0 && !PSEL) psel_gap = 1'b1;
      if (req_ready != 0) begin
        chk($sformatf("t3_grant%0d", n_gr), req_ready, 1 << exp_seq[n_gr]);
        n_gr++;
        if (n_gr == 5) break;
      end
    end
    chk("t3_grant_count", n_gr, 5);
    chk("t3_psel_gap", psel_gap, 0);
    @(posedge PCLK);
    #1;
    req_valid = '0;
    wait_idle();

    // Zero-wait write.
    issue(0, 1'b1, 32'h10, 32'hA5A5);
    wait_rsp(0, lat, en, rd, er);
    chk("t1_latency", lat, 3);
    chk("t1_err", er, 0);
    chk("t1_rdata", rd, 0);
    @(posedge PCLK);
    #1;

    // Read with three wait states.
    wait_states = 3;
    PRDATA = 32'hA5A5;
    issue(0, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, lat, en, rd, er);
    chk("t2_latency", lat, 6);
    chk("t2_penable_cycles", en, 4);
    chk("t2_rdata", rd, 32'hA5A5);
    chk("t2_err", er, 0);
    chk("t2_paddr_hold", PADDR, 32'h10);
    @(posedge PCLK);
    #1;

    // Slave error on req2, then a clean read.
    wait_states = 0;
    PSLVERR = 1'b1;
    PRDATA = 32'h1234;
    issue(2, 1'b0, 32'h20, 32'h0);
    wait_rsp(2, lat, en, rd, er);
    chk("t5_err", er, 1);
    chk("t5_rdata", rd, 32'h1234);
    @(posedge PCLK);
    #1;
    PSLVERR = 1'b0;
    PRDATA = 32'h5678;
    issue(2, 1'b0, 32'h24, 32'h0);
    wait_rsp(2, lat, en, rd, er);
    chk("t5b_err", er, 0);
    chk("t5b_rdata", rd, 32'h5678);
    chk("t5b_latency", lat, 3);
    @(posedge PCLK);
    #1;

    // Hung slave: abort after 16 ACCESS cycles.
    stuck = 1'b1;
    PRDATA = 32'hDEAD;
    issue(1, 1'b0, 32'h30, 32'h0);
    wait_rsp(1, lat, en, rd, er);
    chk("t4_penable_cycles", en, 16);
    chk("t4_latency", lat, 18);
    chk("t4_err", er, 1);
    chk("t4_rdata", rd, 0);
    chk("t4_psel", PSEL, 0);
    chk("t4_busy", busy, 0);
    @(posedge PCLK);
    #1;

    // Reset pulse mid-ACCESS.
    issue(1, 1'b1, 32'h40, 32'h77);
    n_gr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge PCLK);
      if (PENABLE) begin n_gr = 1; break; end
    end
    chk("t6_access_seen", n_gr, 1);
    @(posedge PCLK);
    #2;
    PRESET = 1'b1;
    #1;
    chk("t6_psel_async", PSEL, 0);
    chk("t6_penable_async", PENABLE, 0);
    @(posedge PCLK);
    #2;
    PRESET = 1'b0;
    stuck = 1'b0;
    req_write[1] = 1'b0; req_addr[32 +: 32] = 32'h50;
    req_write[3] = 1'b0; req_addr[96 +: 32] = 32'h58;
    req_valid = 4'b1010;
    n_gr = 0;
    rv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge PCLK);
      if (rsp_valid != 0) rv++;
      if (req_ready != 0) begin
        chk($sformatf("t6_grant%0d", n_gr), req_ready, (n_gr == 0) ? 4'b0010 : 4'b1000);
        seen = req_ready;
        n_gr++;
        @(posedge PCLK);
        #1;
        req_valid = req_valid & ~seen;
        if (n_gr == 2) break;
      end
    end
    chk("t6_grant_count", n_gr, 2);
    chk("t6_no_rsp_after_reset", rv, 0);
    wait_idle();
    repeat (2) @(posedge PCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
